// File: rtl/rpn_eval.sv
// Reverse-Polish evaluator: takes operand/operator/end/clear tokens and drives
// an attached LIFO stack, running binary ALU ops and reporting the final result.
module rpn_eval #(
    parameter int WIDTH    = 32,
    parameter int ST_DEPTH = 16,
    parameter int PT_WIDTH = 4
) (
    input  logic             i_Clk,
    input  logic             i_RstN,
    input  logic             i_TokVld,
    output logic             o_TokRdy,
    input  logic [1:0]       i_TokTyp,
    input  logic [WIDTH-1:0] i_TokDat,
    output logic             o_Push,
    output logic             o_Pop,
    output logic [WIDTH-1:0] o_PushDat,
    input  logic [WIDTH-1:0] i_PopDat,
    input  logic             i_Empty,
    input  logic             i_Full,
    output logic             o_ResVld,
    output logic [WIDTH-1:0] o_Res,
    output logic [1:0]       o_Err
);

    localparam int CNT_W = PT_WIDTH + 1;

    localparam logic [1:0] TOK_OPND = 2'b00;
    localparam logic [1:0] TOK_OPER = 2'b01;
    localparam logic [1:0] TOK_END  = 2'b10;
    localparam logic [1:0] TOK_CLR  = 2'b11;

    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_SUB = 3'd1;
    localparam logic [2:0] OP_MUL = 3'd2;
    localparam logic [2:0] OP_AND = 3'd3;
    localparam logic [2:0] OP_OR  = 3'd4;
    localparam logic [2:0] OP_XOR = 3'd5;

    localparam logic [1:0] ERR_NONE  = 2'b00;
    localparam logic [1:0] ERR_UNDER = 2'b01;
    localparam logic [1:0] ERR_OVER  = 2'b10;
    localparam logic [1:0] ERR_ILLOP = 2'b11;

    typedef enum logic [2:0] {IDLE, POP_B, POP_A, EXEC, POP_R} state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [2:0]         op_q, op_d;
    logic [WIDTH-1:0]   a_q, a_d, b_q, b_d, res_q, res_d;
    logic               res_vld_q, res_vld_d;
    logic [1:0]         err_q, err_d;
    logic               clr_q, clr_d;
    logic [WIDTH-1:0]   alu;

    always_comb begin
        case (op_q)
            OP_ADD:  alu = a_q + b_q;
            OP_SUB:  alu = a_q - b_q;
            OP_MUL:  alu = a_q * b_q;
            OP_AND:  alu = a_q & b_q;
            OP_OR:   alu = a_q | b_q;
            OP_XOR:  alu = a_q ^ b_q;
            default: alu = '0;
        endcase
    end

    always_ff @(posedge i_Clk or negedge i_RstN) begin
        if (!i_RstN) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            op_q      <= OP_ADD;
            a_q       <= '0;
            b_q       <= '0;
            res_q     <= '0;
            res_vld_q <= 1'b0;
            err_q     <= ERR_NONE;
            clr_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            op_q      <= op_d;
            a_q       <= a_d;
            b_q       <= b_d;
            res_q     <= res_d;
            res_vld_q <= res_vld_d;
            err_q     <= err_d;
            clr_q     <= clr_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        op_d      = op_q;
        a_d       = a_q;
        b_d       = b_q;
        res_d     = res_q;
        res_vld_d = 1'b0;
        err_d     = err_q;
        clr_d     = clr_q;
        o_Push    = 1'b0;
        o_Pop     = 1'b0;
        o_PushDat = '0;
        case (state_q)
            IDLE: begin
                if (i_TokVld) begin
                    case (i_TokTyp)
                        TOK_OPND: begin
                            if (cnt_q < CNT_W'(ST_DEPTH) && !i_Full) begin
                                o_Push    = 1'b1;
                                o_PushDat = i_TokDat;
                                cnt_d     = cnt_q + CNT_W'(1);
                            end else begin
                                err_d = ERR_OVER;
                            end
                        end
                        TOK_OPER: begin
                            if (i_TokDat[2:0] > OP_XOR) begin
                                err_d = ERR_ILLOP;
                            end else if (cnt_q < CNT_W'(2)) begin
                                err_d = ERR_UNDER;
                            end else begin
                                op_d    = i_TokDat[2:0];
                                state_d = POP_B;
                            end
                        end
                        TOK_END: begin
                            if (cnt_q == CNT_W'(1)) begin
                                clr_d   = 1'b0;
                                state_d = POP_R;
                            end else begin
                                err_d     = ERR_UNDER;
                                res_d     = '0;
                                res_vld_d = 1'b1;
                            end
                        end
                        default: begin
                            err_d = ERR_NONE;
                            if (cnt_q != '0) begin
                                clr_d   = 1'b1;
                                state_d = POP_R;
                            end
                        end
                    endcase
                end
            end
            POP_B, POP_A: begin
                // An empty stack here means the count lost sync: flag and resync.
                if (i_Empty && cnt_q != '0) begin
                    err_d   = ERR_UNDER;
                    cnt_d   = '0;
                    state_d = IDLE;
                end else begin
                    o_Pop = 1'b1;
                    if (state_q == POP_B) begin
                        b_d     = i_PopDat;
                        state_d = POP_A;
                    end else begin
                        a_d     = i_PopDat;
                        state_d = EXEC;
                    end
                end
            end
            EXEC: begin
                o_Push    = 1'b1;
                o_PushDat = alu;
                cnt_d     = cnt_q - CNT_W'(1);
                state_d   = IDLE;
            end
            POP_R: begin
                // Shared by end (one pop, with result) and clear (pop until empty).
                o_Pop = 1'b1;
                cnt_d = cnt_q - CNT_W'(1);
                if (!clr_q) begin
                    res_d     = i_PopDat;
                    res_vld_d = 1'b1;
                end
                if (cnt_q <= CNT_W'(1)) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign o_TokRdy = (state_q == IDLE);
    assign o_ResVld = res_vld_q;
    assign o_Res    = res_q;
    assign o_Err    = err_q;

endmodule

// File: tb/tb_rpn_eval.sv
// Scoreboard bench for rpn_eval with a behavioural LIFO stack attached.
module tb_rpn_eval;

    localparam int W = 32;
    localparam int D = 16;

    logic         clk = 1'b0;
    logic         rstn;
    logic         tok_vld, tok_rdy;
    logic [1:0]   tok_typ;
    logic [W-1:0] tok_dat;
    logic         push, pop;
    logic [W-1:0] push_dat, pop_dat;
    logic         empty, full;
    logic         res_vld;
    logic [W-1:0] res;
    logic [1:0]   err;

    always #5 clk = ~clk;

    rpn_eval #(.WIDTH(W), .ST_DEPTH(D), .PT_WIDTH(4)) dut (
        .i_Clk(clk), .i_RstN(rstn),
        .i_TokVld(tok_vld), .o_TokRdy(tok_rdy), .i_TokTyp(tok_typ), .i_TokDat(tok_dat),
        .o_Push(push), .o_Pop(pop), .o_PushDat(push_dat),
        .i_PopDat(pop_dat), .i_Empty(empty), .i_Full(full),
        .o_ResVld(res_vld), .o_Res(res), .o_Err(err)
    );

    // Behavioural stack sharing the evaluator's reset
    logic [W-1:0] stk [D];
    logic [4:0]   sp;

    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sp <= '0;
        end else if (push && sp < 5'(D)) begin
            stk[sp[3:0]] <= push_dat;
            sp <= sp + 5'd1;
        end else if (pop && sp != 5'd0) begin
            sp <= sp - 5'd1;
        end
    end

    assign empty   = (sp == 5'd0);
    assign full    = (sp >= 5'(D));
    assign pop_dat = empty ? '0 : stk[4'(sp - 5'd1)];

    typedef struct {logic is_push; logic [W-1:0] dat;} sop_t;
    typedef struct {logic [W-1:0] res; logic [1:0] err;} res_t;
    sop_t sq[$];
    res_t rq[$];
    sop_t se;
    res_t re;

    int nchk = 0;
    int nerr = 0;

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_err(input string name, input logic [1:0] exp);
        chk(name, W'(err), W'(exp));
    endtask

    task automatic ep(input logic [W-1:0] d); sq.push_back('{1'b1, d}); endtask
    task automatic eo(input logic [W-1:0] d); sq.push_back('{1'b0, d}); endtask
    task automatic er(input logic [W-1:0] r, input logic [1:0] e); rq.push_back('{r, e}); endtask

    // Monitor: compares every stack strobe and result strobe against the queues
    always @(negedge clk) begin
        if (rstn) begin
            if (push && pop) begin
                nchk++;
                nerr++;
                $display("FAIL push_pop_overlap: got push=1 pop=1 expected at most one");
            end
            if (push || pop) begin
                if (sq.size() == 0) begin
                    nchk++;
                    nerr++;
                    $display("FAIL unexpected_stack_op: got push=%0b pop=%0b expected none", push, pop);
                end else begin
                    se = sq.pop_front();
                    chk("stack_op_is_push", W'(push), W'(se.is_push));
                    chk("stack_op_data", push ? push_dat : pop_dat, se.dat);
                end
            end
            if (res_vld) begin
                if (rq.size() == 0) begin
                    nchk++;
                    nerr++;
                    $display("FAIL unexpected_result: got res=%0h expected none", res);
                end else begin
                    re = rq.pop_front();
                    chk("result_value", res, re.res);
                    chk("result_err", W'(err), W'(re.err));
                end
            end
        end
    end

    task automatic send(input logic [1:0] t, input logic [W-1:0] d);
        int n = 0;
        tok_vld = 1'b1;
        tok_typ = t;
        tok_dat = d;
        @(negedge clk);
        while (!tok_rdy && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!tok_rdy) begin
            nchk++;
            nerr++;
            $display("FAIL tok_rdy_timeout: got rdy=0 expected rdy=1 within 100 cycles");
        end
        @(posedge clk);
        #1;
        tok_vld = 1'b0;
        $display("token typ=%0d dat=%0h err=%0d", t, d, err);
    endtask

    task automatic drain(input string name);
        int n = 0;
        while ((sq.size() != 0 || rq.size() != 0 || !tok_rdy) && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        repeat (2) @(posedge clk);
        #1;
        chk({name, "_stack_ops_done"}, W'(sq.size()), '0);
        chk({name, "_results_done"}, W'(rq.size()), '0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish before 200us");
        $fatal(1);
    end

    initial begin
        rstn    = 1'b0;
        tok_vld = 1'b0;
        tok_typ = 2'b00;
        tok_dat = '0;
        #12;
        chk("reset_tok_rdy", W'(tok_rdy), W'(1));
        chk("reset_push", W'(push), '0);
        chk("reset_pop", W'(pop), '0);
        chk("reset_res_vld", W'(res_vld), '0);
        chk("reset_res", res, '0);
        chk_err("reset_err", 2'b00);
        rstn = 1'b1;
        @(posedge clk);
        #1;

        // 3 + 4 = 7
        ep(3); send(2'b00, 3);
        ep(4); send(2'b00, 4);
        eo(4); eo(3); ep(7); send(2'b01, 0);
        eo(7); er(7, 2'b00); send(2'b10, 0);
        drain("add");
        chk_err("add_err", 2'b00);

        // 3 - 5 wraps
        ep(3); send(2'b00, 3);
        ep(5); send(2'b00, 5);
        eo(5); eo(3); ep(32'hFFFF_FFFE); send(2'b01, 1);
        eo(32'hFFFF_FFFE); er(32'hFFFF_FFFE, 2'b00); send(2'b10, 0);
        drain("sub");

        // (12 & 10) | 3 = 11
        ep(12); send(2'b00, 12);
        ep(10); send(2'b00, 10);
        eo(10); eo(12); ep(8); send(2'b01, 3);
        ep(3); send(2'b00, 3);
        eo(3); eo(8); ep(11); send(2'b01, 4);
        eo(11); er(11, 2'b00); send(2'b10, 0);
        drain("and_or");

        // Overflow on the 17th operand, then clear pops all 16
        for (int i = 0; i < 17; i++) begin
            if (i < 16) ep(W'(100 + i));
            send(2'b00, W'(100 + i));
        end
        chk_err("overflow_err", 2'b10);
        for (int i = 15; i >= 0; i--) eo(W'(100 + i));
        send(2'b11, 0);
        drain("clear_full");
        chk_err("clear_err", 2'b00);
        er(0, 2'b01); send(2'b10, 0);
        drain("end_empty");
        chk_err("end_empty_err", 2'b01);
        send(2'b11, 0);

        // Underflow: ADD on a single operand leaves the stack alone
        ep(9); send(2'b00, 9);
        send(2'b01, 0);
        chk_err("underflow_err", 2'b01);
        eo(9); er(9, 2'b01); send(2'b10, 0);
        drain("underflow");
        send(2'b11, 0);
        chk_err("underflow_clear_err", 2'b00);

        // Illegal op, then 6 * 7 with the error still sticky
        send(2'b01, 6);
        chk_err("illegal_err", 2'b11);
        ep(6); send(2'b00, 6);
        ep(7); send(2'b00, 7);
        eo(7); eo(6); ep(42); send(2'b01, 2);
        eo(42); er(42, 2'b11); send(2'b10, 0);
        drain("mul");
        chk_err("mul_sticky_err", 2'b11);

        // Reset asserted while in POP_A
        ep(2); send(2'b00, 2);
        ep(3); send(2'b00, 3);
        eo(3); send(2'b01, 5);
        @(posedge clk);
        #1;
        rstn = 1'b0;
        #1;
        chk("rst_mid_push", W'(push), '0);
        chk("rst_mid_pop", W'(pop), '0);
        chk("rst_mid_push_dat", push_dat, '0);
        chk("rst_mid_res_vld", W'(res_vld), '0);
        chk("rst_mid_res", res, '0);
        chk_err("rst_mid_err", 2'b00);
        #5;
        rstn = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_release_tok_rdy", W'(tok_rdy), W'(1));
        drain("reset");

        // Count and stack stay consistent after the mid-sequence reset
        ep(1); send(2'b00, 1);
        ep(1); send(2'b00, 1);
        eo(1); eo(1); ep(2); send(2'b01, 0);
        eo(2); er(2, 2'b00); send(2'b10, 0);
        drain("post_reset");

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
